// File: rtl/hex_keypad_encoder.sv
// hex_keypad_encoder: 4x4 matrix keypad scanner with debounce and hex encode.
// Optional auto-repeat while a key stays held: define KEYPAD_REPEAT_EN.
module hex_keypad_encoder #(
  parameter int oldHz          = 50_000_000,
  parameter int scanHz         = 1_000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 500
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Row_in,
  output logic [3:0] Col_out,
  output logic [3:0] Key_out,
  output logic       Key_valid,
  output logic       Key_held
);

  localparam int TP = oldHz / scanHz;
  localparam int PW = (TP > 1) ? $clog2(TP) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
`endif

  localparam logic [2:0] S_SCAN     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_ACCEPT   = 3'd2;
  localparam logic [2:0] S_HELD     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [RW-1:0] rep_q, rep_d;
`endif

  logic       tick;
  logic       rows_idle;
  logic [1:0] win_row;
  logic       cnt_last;

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else if (!rows[3]) r = 2'd3;
    return r;
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] col);
    logic [1:0] c;
    c = 2'd0;
    if (!col[0])      c = 2'd0;
    else if (!col[1]) c = 2'd1;
    else if (!col[2]) c = 2'd2;
    else if (!col[3]) c = 2'd3;
    return c;
  endfunction

  // Physical keypad legend, indexed {row, col}
  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  assign tick      = (pre_q == PW'(TP - 1));
  assign rows_idle = (sync2_q == 4'hF);
  assign win_row   = low_row(sync2_q);
  assign cnt_last  = (cnt_q == CW'(DEBOUNCE_TICKS - 1));

  always_comb begin
    sync1_d = Row_in;
    sync2_d = sync1_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cidx_d  = cidx_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      S_SCAN: begin
        if (tick) begin
          if (rows_idle) begin
            col_d = {col_q[2:0], col_q[3]};
          end else begin
            row_d  = win_row;
            cidx_d = col_idx(col_q);
            cnt_d  = CW'(1);
            if (DEBOUNCE_TICKS == 1) state_d = S_ACCEPT;
            else                     state_d = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (tick) begin
          if (!rows_idle && (win_row == row_q)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_last) state_d = S_ACCEPT;
          end else begin
            cnt_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      S_ACCEPT: begin
        key_d   = key_map(row_q, cidx_q);
        valid_d = 1'b1;
        held_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      S_HELD: begin
        if (tick && rows_idle) begin
          if (DEBOUNCE_TICKS == 1) begin
            cnt_d   = '0;
            held_d  = 1'b0;
            state_d = S_SCAN;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_RELEASE;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (tick) begin
          if (rep_q == RW'(REPEAT_TICKS - 1)) begin
            rep_d   = '0;
            valid_d = ~valid_q;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
      S_RELEASE: begin
        if (tick) begin
          if (rows_idle) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_last) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              state_d = S_SCAN;
            end
          end else begin
            // bounce: back to HELD, key already reported
            cnt_d   = '0;
            state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
      end
      default: begin
        cnt_d   = '0;
        held_d  = 1'b0;
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      pre_q   <= '0;
      state_q <= S_SCAN;
      col_q   <= 4'b1110;
      row_q   <= 2'd0;
      cidx_q  <= 2'd0;
      cnt_q   <= '0;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pre_q   <= pre_d;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cidx_q  <= cidx_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign Col_out   = col_q;
  assign Key_out   = key_q;
  assign Key_valid = valid_q;
  assign Key_held  = held_q;

endmodule

// File: doc/hex_keypad_encoder.md
Name: hex_keypad_encoder

Overview:
Scans a 4x4 matrix hex keypad and encodes each debounced key press into a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the hex-digit-to-7-segment display path. Its Key_out/Key_valid pair is intended to feed Count_in/Load of the board's hex counter. It runs on the 50 MHz board clock and uses an internal scan-rate prescaler.

Parameters:
oldHz, 50_000_000, input clock frequency in Hz
scanHz, 1_000, column-scan tick rate in Hz; tick period TP = oldHz/scanHz clocks
DEBOUNCE_TICKS, 4, consecutive scan ticks a condition must hold to be accepted (>=1)
REPEAT_TICKS, 500, auto-repeat interval in ticks (used only with KEYPAD_REPEAT_EN)

Ports:
Clk        input   1  system clock, rising edge
Reset      input   1  synchronous, active-high reset
Row_in     input   4  keypad rows, active-low, externally pulled up, asynchronous
Col_out    output  4  column drive, active-low, one-cold
Key_out    output  4  hex code of last accepted key
Key_valid  output  1  one-Clk pulse when Key_out is updated
Key_held   output  1  high while an accepted key remains pressed

Behaviour:
- Reset (sampled on Clk edge with Reset=1):
  - Col_out=4'b1110, Key_out=4'h0, Key_valid=0, Key_held=0.
  - Prescaler=0, debounce count=0, state=SCAN, synchronizer flops=4'hF.
- Row_in passes through a 2-flop synchronizer; rows_s is the synchronized value.
- Prescaler counts 0..TP-1. tick=1 for one Clk when count=TP-1, then the count wraps to 0. All FSM decisions occur only on tick cycles.
- Row priority: if several rows_s bits are low, the lowest-index low row is used.
- Column index c: Col_out bit c is low.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states:
  - SCAN: on tick, if rows_s==4'hF, rotate Col_out left (1110->1101->1011->0111->1110). Otherwise latch r and c, freeze Col_out, set count=1, go to DEBOUNCE (or ACCEPT if DEBOUNCE_TICKS==1).
  - DEBOUNCE: on tick, if the same row is still the winning low row, count++. When count reaches DEBOUNCE_TICKS, go to ACCEPT. If rows are all high or a different row wins, clear count and return to SCAN without advancing Col_out.
  - ACCEPT: exactly one Clk (no tick needed). Load Key_out=map(r,c), pulse Key_valid=1, set Key_held=1, go to HELD.
  - HELD: Col_out stays frozen. On tick, if rows_s==4'hF, go to RELEASE with count=1. Otherwise stay.
  - RELEASE: on tick, if rows_s==4'hF, count++. When count reaches DEBOUNCE_TICKS, clear Key_held and go to SCAN. Any low row returns the FSM to HELD (a bounce); no new Key_valid is issued.
- Key_out holds its value until the next ACCEPT.
- Key_valid is never high for two consecutive clocks.
- A second key pressed while in HELD is ignored.
- Press latency, from the rows_s change to Key_valid: at most (4+DEBOUNCE_TICKS)*TP+3 clocks.
- Reset asserted in any state returns all outputs to reset values on the next edge. A key still held when Reset is released is re-detected from SCAN.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: while in HELD, a repeat counter counts ticks. On reaching REPEAT_TICKS, the block re-pulses Key_valid for one Clk with an unchanged Key_out, clears the counter, and repeats. The counter clears on entering HELD and on a bounce back from RELEASE.
- Undefined: no repeat counter is synthesized, and exactly one Key_valid is issued per press.

Test Plan:
Use oldHz=8, scanHz=1 (TP=8), DEBOUNCE_TICKS=3, REPEAT_TICKS=4.
1. Reset, no key pressed, run 40 clks -> Col_out cycles 1110,1101,1011,0111,1110 every 8 clks; Key_valid never 1; Key_out=0.
2. Press key r1/c2, i.e. Row_in=4'b1101 while Col_out=1011, held 60 clks -> exactly one Key_valid pulse with Key_out=4'h6; Key_held=1; Col_out frozen at 1011.
3. Release after case 2 -> Key_held falls after 3 ticks (24 clks ±8); scanning resumes; no extra Key_valid.
4. Press r3/c1 for 1 tick then release (bounce) -> no Key_valid; Key_out keeps its prior value; return to SCAN.
5. Rows 0 and 2 low together on column 3 -> Key_out=4'hA. Assert Reset mid-DEBOUNCE -> next clk Col_out=1110, Key_held=0, Key_out=0.
6. Hold key 9 for 100 ticks -> with KEYPAD_REPEAT_EN defined, Key_valid pulses again every 4 ticks, Key_out=4'h9; with it undefined, a single pulse.
